mono_mode_ctrl: RTL and testbench

- Sequences the 2-bit monochrome display mode consumed by the VGA output colour path: 0 colour, 1 green, 2 amber, 3 greyscale.
- Mode requests come from two sources: a front-panel/joystick button (debounced, with auto-repeat while held) and a CPU I/O-port write.
- Requests are buffered and applied only at the start of vertical sync, so a mode change never tears mid-frame.
- Sits between the system I/O decode, the button input pins and the colour-conversion stage; runs in the VGA clock domain.

---
 rtl/video_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 117 +++++++++++
 rtl/mono_mode_ctrl.sv | 85 ++++++++
 tb/tb_mono_mode_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_pkg
// Brief    : Shared monochrome display mode encodings for the VGA colour path.
// Revision : 1.0
// ============================================================================
package video_pkg;

    typedef logic [1:0] mono_mode_t;

    localparam mono_mode_t MODE_COLOUR = 2'd0;
    localparam mono_mode_t MODE_GREEN  = 2'd1;
    localparam mono_mode_t MODE_AMBER  = 2'd2;
    localparam mono_mode_t MODE_MONO   = 2'd3;

    // Mode sequence wraps from greyscale back to colour.
    function automatic mono_mode_t next_mode(input mono_mode_t m);
        return m + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : Button synchroniser, press/release debounce and frame-based
//            auto-repeat; emits a single-cycle advance per accepted step.
// Revision : 1.0
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 286360,
    parameter int REPEAT_FRAMES   = 30
) (
    input  logic clk_vga,
    input  logic rst_n,
    input  logic btn_n,
    input  logic frame_tick,
    output logic advance
);

    localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int c_REP_W = $clog2(REPEAT_FRAMES + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_FRAMES - 1);

    localparam logic [1:0] c_ST_IDLE         = 2'd0;
    localparam logic [1:0] c_ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] c_ST_HELD         = 2'd2;
    localparam logic [1:0] c_ST_RELEASE_WAIT = 2'd3;

    logic               r_sync1;
    logic               r_sync2;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_REP_W-1:0] r_rep;
    logic [c_REP_W-1:0] w_rep_nxt;
    logic               w_rep_step;
    logic               w_advance;

    // Held-button frames count in HELD and also on a bounce back into HELD.
    assign w_rep_step = frame_tick && !r_sync2 &&
                        ((r_state == c_ST_HELD) || (r_state == c_ST_RELEASE_WAIT));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rep_nxt   = r_rep;
        w_advance   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!r_sync2) begin
                    w_state_nxt = c_ST_PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            c_ST_PRESS_WAIT: begin
                if (r_sync2) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_advance   = 1'b1;
                    w_state_nxt = c_ST_HELD;
                    w_rep_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_ST_HELD: begin
                if (r_sync2) begin
                    w_state_nxt = c_ST_RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            c_ST_RELEASE_WAIT: begin
                if (!r_sync2) begin
                    w_state_nxt = c_ST_HELD;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        if (w_rep_step) begin
            if (r_rep == c_REP_LAST) begin
                w_advance = 1'b1;
                w_rep_nxt = '0;
            end else begin
                w_rep_nxt = r_rep + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_rep   <= '0;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rep   <= w_rep_nxt;
        end
    end

    assign advance = w_advance;

endmodule
`default_nettype wire

// File: rtl/mono_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mono_mode_ctrl
// Brief    : Buffers button and CPU mode requests and applies them to the
//            monochrome mode output at the vertical sync leading edge.
// Revision : 1.0
// ============================================================================
module mono_mode_ctrl
    import video_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES  = 286360,
    parameter int         REPEAT_FRAMES    = 30,
    parameter bit         VSYNC_ACTIVE_LOW = 1'b1,
    parameter mono_mode_t RESET_MODE       = MODE_COLOUR
) (
    input  logic       clk_vga,
    input  logic       rst_n,
    input  logic       btn_n,
    input  logic       vsync,
    input  logic       cpu_we,
    input  logic [1:0] cpu_wdata,
    output logic [1:0] mode,
    output logic       pending,
    output logic       mode_changed
);

    logic       w_vsync_act;
    logic       r_vsync_act_q;
    logic       w_frame_tick;
    logic       w_advance;
    mono_mode_t r_target;
    mono_mode_t w_target_nxt;
    mono_mode_t r_mode;
    logic       r_pending;
    logic       r_mode_changed;

    assign w_vsync_act  = VSYNC_ACTIVE_LOW ? ~vsync : vsync;
    assign w_frame_tick = w_vsync_act & ~r_vsync_act_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_FRAMES   (REPEAT_FRAMES)
    ) u_btn_debounce (
        .clk_vga    (clk_vga),
        .rst_n      (rst_n),
        .btn_n      (btn_n),
        .frame_tick (w_frame_tick),
        .advance    (w_advance)
    );

    // A CPU write overrides a coincident button advance.
    always_comb begin
        w_target_nxt = r_target;
        if (cpu_we) begin
            w_target_nxt = cpu_wdata;
        end else if (w_advance) begin
            w_target_nxt = next_mode(r_target);
        end
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_act_q  <= 1'b0;
            r_target       <= RESET_MODE;
            r_mode         <= RESET_MODE;
            r_pending      <= 1'b0;
            r_mode_changed <= 1'b0;
        end else begin
            r_vsync_act_q  <= w_vsync_act;
            r_target       <= w_target_nxt;
            r_pending      <= (r_target != r_mode);
            r_mode_changed <= w_frame_tick && (r_target != r_mode);
            // Apply samples the target held before the edge cycle.
            if (w_frame_tick) begin
                r_mode <= r_target;
            end
        end
    end

    assign mode         = r_mode;
    assign pending      = r_pending;
    assign mode_changed = r_mode_changed;

endmodule
`default_nettype wire

// File: tb/tb_mono_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mono_mode_ctrl
// Brief    : Directed and random stimulus for mono_mode_ctrl against a
//            run-length/frame-count reference model.
// Revision : 1.0
// ============================================================================
module tb_mono_mode_ctrl;

    localparam int c_DEB   = 16;
    localparam int c_REP   = 2;
    localparam int c_FRAME = 40;

    logic       clk_vga = 1'b0;
    logic       rst_n;
    logic       btn_n;
    logic       vsync;
    logic       cpu_we;
    logic [1:0] cpu_wdata;
    logic [1:0] mode;
    logic       pending;
    logic       mode_changed;

    int n_vec  = 0;
    int n_err  = 0;
    int pulses = 0;
    int fpos   = 1;
    bit vs_force = 1'b0;
    int hold   = 0;

    // Reference model state
    bit         m_sy1, m_sy2, m_pressed, m_vprev, m_pend, m_chg;
    int         m_run, m_rep;
    logic [1:0] m_target, m_mode;

    mono_mode_ctrl #(
        .DEBOUNCE_CYCLES  (c_DEB),
        .REPEAT_FRAMES    (c_REP),
        .VSYNC_ACTIVE_LOW (1'b1),
        .RESET_MODE       (2'd0)
    ) u_dut (
        .clk_vga      (clk_vga),
        .rst_n        (rst_n),
        .btn_n        (btn_n),
        .vsync        (vsync),
        .cpu_we       (cpu_we),
        .cpu_wdata    (cpu_wdata),
        .mode         (mode),
        .pending      (pending),
        .mode_changed (mode_changed)
    );

    always #5 clk_vga = ~clk_vga;

    task automatic model_reset();
        m_sy1 = 1'b1; m_sy2 = 1'b1; m_pressed = 1'b0;
        m_run = 0; m_rep = 0;
        m_target = 2'd0; m_mode = 2'd0;
        m_pend = 1'b0; m_chg = 1'b0; m_vprev = 1'b0;
    endtask

    // Press/release accepted after c_DEB+1 consecutive disagreeing samples;
    // while pressed, every c_REP-th frame edge advances again.
    task automatic model_step();
        bit want, tick, adv;
        if (!rst_n) begin
            model_reset();
            return;
        end
        want = !m_sy2;
        tick = (vsync == 1'b0) && !m_vprev;
        adv  = 1'b0;
        if (want != m_pressed) begin
            m_run++;
            if (m_run == c_DEB + 1) begin
                m_pressed = want;
                m_run     = 0;
                if (want) begin
                    adv   = 1'b1;
                    m_rep = 0;
                end
            end
        end else begin
            m_run = 0;
            if (m_pressed && tick) begin
                m_rep++;
                if (m_rep == c_REP) begin
                    adv   = 1'b1;
                    m_rep = 0;
                end
            end
        end
        m_pend = (m_target != m_mode);
        m_chg  = tick && (m_target != m_mode);
        if (tick) m_mode = m_target;
        if (cpu_we)   m_target = cpu_wdata;
        else if (adv) m_target = m_target + 2'd1;
        m_vprev = (vsync == 1'b0);
        m_sy2   = m_sy1;
        m_sy1   = btn_n;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_vga);
        model_step();
        #1;
        chk("mode", 32'(mode), 32'(m_mode));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("mode_changed", 32'(mode_changed), 32'(m_chg));
        if (mode_changed === 1'b1) pulses++;
        if (vs_force) begin
            vsync = 1'b0;
        end else begin
            fpos  = (fpos + 1) % c_FRAME;
            vsync = (fpos < 3) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic align(input int p);
        for (int i = 0; i < 2 * c_FRAME && fpos != p; i++) step();
        chk("align", 32'(fpos), 32'(p));
    endtask

    task automatic cpu_write(input logic [1:0] v);
        cpu_we = 1'b1; cpu_wdata = v;
        step();
        cpu_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; btn_n = 1'b1; vsync = 1'b1; cpu_we = 1'b0; cpu_wdata = 2'd0;
        model_reset();
        #3;
        chk("reset_mode", 32'(mode), 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);
        chk("reset_changed", 32'(mode_changed), 32'd0);
        steps(2);
        #3 rst_n = 1'b1;

        // Idle frames: nothing moves
        pulses = 0;
        steps(3 * c_FRAME);
        chk("idle_pulses", 32'(pulses), 32'd0);
        chk("idle_mode", 32'(mode), 32'd0);

        // CPU write mid-frame, applied at next vsync, single pulse
        align(20);
        cpu_write(2'd2);
        step();
        chk("wr_pending", 32'(pending), 32'd1);
        pulses = 0;
        steps(c_FRAME);
        chk("wr_mode", 32'(mode), 32'd2);
        chk("wr_pulses", 32'(pulses), 32'd1);
        chk("wr_pending_clr", 32'(pending), 32'd0);
        pulses = 0;
        steps(c_FRAME);
        chk("wr_no_repulse", 32'(pulses), 32'd0);

        // Bouncy press: one advance only
        cpu_write(2'd0);
        steps(c_FRAME + 5);
        pulses = 0;
        for (int g = 0; g < 3; g++) begin
            btn_n = 1'b0; steps(5);
            btn_n = 1'b1; steps(5);
        end
        btn_n = 1'b0; steps(20);
        btn_n = 1'b1; steps(20);
        steps(c_FRAME + 5);
        chk("bounce_mode", 32'(mode), 32'd1);
        chk("bounce_pulses", 32'(pulses), 32'd1);

        // Held button auto-repeat from greyscale
        cpu_write(2'd3);
        steps(c_FRAME + 5);
        chk("rep_start", 32'(mode), 32'd3);
        align(1);
        btn_n = 1'b0;
        steps(205);
        chk("rep_mode", 32'(mode), 32'd2);
        chk("rep_pending", 32'(pending), 32'd0);
        btn_n = 1'b1;
        steps(3 * c_FRAME);
        chk("rep_release", 32'(mode), 32'd2);

        // CPU write coincident with the debounced advance wins
        cpu_write(2'd1);
        steps(c_FRAME + 5);
        align(1);
        btn_n = 1'b0;
        steps(c_DEB + 2);
        cpu_write(2'd3);
        btn_n = 1'b1;
        steps(60);
        chk("collide_mode", 32'(mode), 32'd3);

        // Write landing in the apply cycle waits a frame
        align(0);
        cpu_write(2'd2);
        steps(5);
        chk("late_wr_held", 32'(mode), 32'd3);
        steps(c_FRAME);
        chk("late_wr_applied", 32'(mode), 32'd2);

        // Continuous active vsync gives a single apply
        align(20);
        cpu_write(2'd1);
        pulses = 0;
        vs_force = 1'b1; vsync = 1'b0;
        steps(50);
        cpu_write(2'd0);
        steps(50);
        chk("cont_pulses", 32'(pulses), 32'd1);
        chk("cont_mode", 32'(mode), 32'd1);
        chk("cont_pending", 32'(pending), 32'd1);
        vs_force = 1'b0; fpos = 3; vsync = 1'b1;
        steps(c_FRAME + 5);
        chk("cont_next", 32'(mode), 32'd0);

        // Cancel: write back the applied value while a change is pending
        align(10);
        cpu_write(2'd3);
        cpu_write(2'd0);
        pulses = 0;
        steps(c_FRAME + 5);
        chk("cancel_pulses", 32'(pulses), 32'd0);

        // Reset while held and pending; full re-debounce afterwards
        align(1);
        btn_n = 1'b0;
        steps(22);
        chk("pre_rst_pending", 32'(pending), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_changed", 32'(mode_changed), 32'd0);
        model_reset();
        steps(2);
        #3 rst_n = 1'b1;
        steps(c_DEB + 3);
        chk("post_rst_wait", 32'(pending), 32'd0);
        step();
        chk("post_rst_adv", 32'(pending), 32'd1);
        btn_n = 1'b1;
        steps(30);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                btn_n = 1'($urandom_range(0, 1));
                hold  = $urandom_range(1, 50);
            end else begin
                hold--;
            end
            cpu_we    = ($urandom_range(0, 24) == 0);
            cpu_wdata = 2'($urandom_range(0, 3));
            step();
        end
        cpu_we = 1'b0;
        steps(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
